// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: arbitrates,
// tracks the owner, routes responses back and aborts on response timeout.
// Build option: define ARB_RR_EN for round-robin; otherwise LS has fixed priority over IF.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_f,
    output logic                bus_err,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_LS_WAIT = 2'd2
    } state_t;

    // Timeout fires in the wait cycle that would bring the count to TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_bus_err;

    logic w_idle;
    logic w_wait;
    logic w_sel_ls;
    logic w_sel_if;
    logic w_issue;
    logic w_accept;
    logic w_timeout;
    logic w_done;

`ifdef ARB_RR_EN
    logic r_last_ls;
    assign w_sel_ls = ls_req && (!if_req || !r_last_ls);
`else
    assign w_sel_ls = ls_req;
`endif
    assign w_sel_if = if_req && !w_sel_ls;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_wait    = (r_state == ST_IF_WAIT) || (r_state == ST_LS_WAIT);
    assign w_issue   = w_idle && (if_req || ls_req);
    assign w_accept  = w_issue && mem_ready;
    assign w_timeout = w_wait && !mem_rvalid && (r_wait_cnt == TO_LAST);
    assign w_done    = w_wait && (mem_rvalid || w_timeout);

    // Request fields follow the live selection; nothing is latched before acceptance.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (w_issue) begin
            if (w_sel_ls) begin
                mem_we    = ls_we;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                mem_be    = ls_be;
            end else begin
                mem_addr  = if_addr;
                mem_be    = '1;
            end
        end
    end

    assign mem_req   = w_issue;
    assign if_gnt    = w_accept && w_sel_if;
    assign ls_gnt    = w_accept && w_sel_ls;
    assign if_rvalid = w_done && (r_state == ST_IF_WAIT);
    assign ls_rvalid = w_done && (r_state == ST_LS_WAIT);
    assign if_rdata  = ((r_state == ST_IF_WAIT) && mem_rvalid) ? mem_rdata : '0;
    assign ls_rdata  = ((r_state == ST_LS_WAIT) && mem_rvalid) ? mem_rdata : '0;
    assign stall_f   = if_req && !if_gnt;
    assign bus_err   = r_bus_err;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
            r_bus_err  <= 1'b0;
`ifdef ARB_RR_EN
            r_last_ls  <= 1'b1;
`endif
        end else begin
            r_bus_err <= w_timeout;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= w_sel_ls ? ST_LS_WAIT : ST_IF_WAIT;
                        r_wait_cnt <= 8'd0;
`ifdef ARB_RR_EN
                        r_last_ls  <= w_sel_ls;
`endif
                    end
                end
                ST_IF_WAIT, ST_LS_WAIT: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4; expectations follow the
// arbitration mode selected by ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];
  logic        exp_ls;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled 1ns later
  task automatic quiet_inputs();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue_ls_load(input logic [31:0] addr);
    next_cycle();
    quiet_inputs();
    ls_req = 1'b1; ls_addr = addr; mem_ready = 1'b1;
    settle();
    check_val("load_gnt", 32'(ls_gnt), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    quiet_inputs();
    reset = 1'b0;

    // reset state with both requesting
    next_cycle();
    if_req = 1'b1; ls_req = 1'b1; mem_ready = 1'b1; if_addr = 32'h40; ls_addr = 32'h80;
    settle();
`ifdef ARB_RR_EN
    exp_ls = 1'b0;
`else
    exp_ls = 1'b1;
`endif
    check_val("rst_ls_gnt", 32'(ls_gnt), 32'(exp_ls));
    check_val("rst_if_gnt", 32'(if_gnt), 32'(!exp_ls));
    check_val("rst_bus_err", 32'(bus_err), 32'd0);
    check_val("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_val("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);
    quiet_inputs();
    next_cycle();
    reset = 1'b1;

    // fetch alone, 3-cycle memory
    next_cycle();
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    settle();
    check_val("if_mem_req", 32'(mem_req), 32'd1);
    check_val("if_mem_addr", mem_addr, 32'h100);
    check_val("if_mem_be", 32'(mem_be), 32'hF);
    check_val("if_mem_we", 32'(mem_we), 32'd0);
    check_val("if_gnt", 32'(if_gnt), 32'd1);
    check_val("if_stall_gnt", 32'(stall_f), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      quiet_inputs();
      settle();
      check_val("if_wait_mem_req", 32'(mem_req), 32'd0);
      check_val("if_wait_rvalid", 32'(if_rvalid), 32'd0);
    end
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    settle();
    check_val("if_rvalid", 32'(if_rvalid), 32'd1);
    check_val("if_rdata", if_rdata, exp_q.pop_front());
    check_val("if_ls_rvalid", 32'(ls_rvalid), 32'd0);

    // store with memory not ready for two cycles
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      quiet_inputs();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234; ls_be = 4'b0011;
      mem_ready = (c == 2);
      settle();
      check_val("st_mem_req", 32'(mem_req), 32'd1);
      check_val("st_mem_we", 32'(mem_we), 32'd1);
      check_val("st_mem_wdata", mem_wdata, 32'h1234);
      check_val("st_mem_be", 32'(mem_be), 32'h3);
      check_val("st_ls_gnt", 32'(ls_gnt), 32'(c == 2));
    end
    next_cycle();
    quiet_inputs();
    mem_rvalid = 1'b1;
    settle();
    check_val("st_ack", 32'(ls_rvalid), 32'd1);
    check_val("st_ack_if", 32'(if_rvalid), 32'd0);

    // both requesting continuously, 1-cycle memory
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      quiet_inputs();
      if_req = 1'b1; if_addr = 32'h300; ls_req = 1'b1; ls_addr = 32'h400; mem_ready = 1'b1;
      settle();
`ifdef ARB_RR_EN
      exp_ls = 1'(i % 2);
`else
      exp_ls = 1'b1;
`endif
      check_val("arb_ls_gnt", 32'(ls_gnt), 32'(exp_ls));
      check_val("arb_if_gnt", 32'(if_gnt), 32'(!exp_ls));
      check_val("arb_stall", 32'(stall_f), 32'(exp_ls));
      next_cycle();
      mem_rvalid = 1'b1; mem_rdata = 32'(i + 5);
      settle();
      check_val("arb_stall_wait", 32'(stall_f), 32'd1);
      check_val("arb_ls_rvalid", 32'(ls_rvalid), 32'(exp_ls));
      check_val("arb_if_rvalid", 32'(if_rvalid), 32'(!exp_ls));
    end

    // timeout: four wait cycles, then bus_err one cycle later
    issue_ls_load(32'h500);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      quiet_inputs();
      settle();
      check_val("to_ls_rvalid", 32'(ls_rvalid), 32'(c == 4));
      check_val("to_ls_rdata", ls_rdata, 32'd0);
      check_val("to_bus_err_early", 32'(bus_err), 32'd0);
    end
    next_cycle();
    settle();
    check_val("to_bus_err", 32'(bus_err), 32'd1);
    check_val("to_state_idle", 32'(dbg_state), 32'd0);
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    settle();
    check_val("to_bus_err_clr", 32'(bus_err), 32'd0);
    check_val("stray_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check_val("stray_if_rvalid", 32'(if_rvalid), 32'd0);
    check_val("stray_ls_rdata", ls_rdata, 32'd0);

    // response in the timeout cycle wins over the error
    issue_ls_load(32'h600);
    exp_q.push_back(32'h55);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      quiet_inputs();
      settle();
      check_val("race_wait", 32'(ls_rvalid), 32'd0);
    end
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    settle();
    check_val("race_rvalid", 32'(ls_rvalid), 32'd1);
    check_val("race_rdata", ls_rdata, exp_q.pop_front());
    next_cycle();
    quiet_inputs();
    settle();
    check_val("race_no_err", 32'(bus_err), 32'd0);

    // reset asserted while LS owns the port
    issue_ls_load(32'h700);
    next_cycle();
    quiet_inputs();
    settle();
    check_val("mid_state_ls", 32'(dbg_state), 32'd2);
    next_cycle();
    reset = 1'b0;
    settle();
    check_val("mid_rst_state", 32'(dbg_state), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    settle();
    check_val("mid_rst_rvalid", 32'(ls_rvalid), 32'd0);
    next_cycle();
    reset = 1'b1;
    settle();
    check_val("mid_post_rvalid", 32'(ls_rvalid), 32'd0);
    check_val("mid_post_rdata", ls_rdata, 32'd0);
    check_val("mid_post_state", 32'(dbg_state), 32'd0);
    next_cycle();
    quiet_inputs();
    settle();
    check_val("mid_post_err", 32'(bus_err), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the RV32I instruction-fetch stage and the load/store (MEM) stage. It arbitrates, issues one transaction at a time, tracks its owner, routes the response back, enforces a response timeout, and produces the fetch-stall signal consumed by the pipeline control.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` bits.
- `TIMEOUT`, 255: cycles to wait for `mem_rvalid` before aborting; range 1..255.

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  fetch request accepted by memory this cycle.
- `if_rvalid`  out  1  fetch response valid; one-cycle pulse.
- `if_rdata`  out  DATA_W  fetch data, valid with `if_rvalid`.
- `ls_req`  in  1  load/store request; held until `ls_gnt`.
- `ls_we`  in  1  1 = store.
- `ls_addr`  in  ADDR_W  load/store address.
- `ls_wdata`  in  DATA_W  store data.
- `ls_be`  in  DATA_W/8  byte enables.
- `ls_gnt`  out  1  load/store request accepted this cycle.
- `ls_rvalid`  out  1  load data or store ack; one-cycle pulse.
- `ls_rdata`  out  DATA_W  load data, valid with `ls_rvalid`.
- `mem_req`  out  1  request to memory.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`  out  1/ADDR_W/DATA_W/DATA_W/8  request fields.
- `mem_ready`  in  1  memory accepts the request when `mem_req && mem_ready`.
- `mem_rvalid`  in  1  response valid (read data or write ack).
- `mem_rdata`  in  DATA_W  response data.
- `stall_f`  out  1  `if_req && !if_gnt`.
- `bus_err`  out  1  registered one-cycle pulse on timeout.

## Operation
- States: IDLE, IF_WAIT, LS_WAIT.
- IDLE: select a requester combinationally; drive `mem_req` and fields from it (fetch: `mem_we`=0, `mem_be`=all ones, `mem_wdata`=0). With no requester, `mem_req`=0 and fields 0.
- Selection is re-evaluated every IDLE cycle. The selection is not locked before acceptance, so a dropped request is never issued.
- Accept (`mem_req && mem_ready`): pulse `if_gnt`/`ls_gnt` combinationally in the same cycle, latch the owner, and go to IF_WAIT/LS_WAIT.
- WAIT states: `mem_req`=0. On `mem_rvalid`, pass `mem_rdata` through to the owner's `rdata` with its `rvalid`, same cycle, and return to IDLE.
- `mem_rvalid` in IDLE is ignored.
- Timeout: an 8-bit wait counter clears on accept and increments each WAIT cycle without `mem_rvalid`. When it reaches `TIMEOUT`, the owner gets `rvalid` with `rdata`=0, `bus_err` pulses the next cycle, and the FSM returns to IDLE. If `mem_rvalid` arrives in the same cycle, the response wins and there is no error.
- Non-owner `rvalid`/`gnt` are always 0, and `rdata` outputs are 0 when not valid.
- Reset (any time, including mid-transaction): state=IDLE, counter=0, `last_owner`=LS, `bus_err`=0. All combinational outputs follow from IDLE with inputs. An in-flight response is dropped.

## Timing
- Minimum 2 cycles per transaction (accept, then response at the earliest the next cycle). The next issue is from IDLE on the cycle after the response.
- Grant-to-rvalid latency equals memory latency, up to `TIMEOUT`.
- `stall_f` is combinational; it is high during every cycle fetch waits, including while LS owns the port.

## Configuration
- `ARB_RR_EN` defined: round-robin. On a simultaneous request, grant the requester that is not `last_owner`. `last_owner` updates on each accept.
- `ARB_RR_EN` undefined: fixed priority, LS over IF. `last_owner` is unused.

## Test plan
- Reset with both requests high, `mem_ready`=1 → `ls_gnt`=1 (fixed) / `if_gnt`=1 (RR, `last_owner`=LS). `bus_err`=0, `if_rvalid`=`ls_rvalid`=0.
- Fetch alone at `0x100`, memory returns `0xDEADBEEF` after 3 cycles → `if_gnt` on accept, `if_rvalid` with `0xDEADBEEF` 3 cycles later, `stall_f`=0 from the grant cycle.
- Store `be`=`0b0011`, `wdata`=`0x1234`, with `mem_ready` low for 2 cycles → `mem_req` held with stable fields, `ls_gnt` on the 3rd cycle, ack routed to `ls_rvalid`.
- Both requesting continuously, 1-cycle memory → RR: grants alternate LS/IF. Fixed: IF starved and `stall_f` stays 1.
- `TIMEOUT`=4 with no response → owner `rvalid`, `rdata`=0 after 4 WAIT cycles, `bus_err` pulse one cycle later; a later stray `mem_rvalid` in IDLE is ignored.
- Reset asserted in LS_WAIT, then response arrives → no `ls_rvalid`, state IDLE.
